// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, ALU function codes and FSM encoding shared by the ALU command front-end.
package alu_ctrl_pkg;
  localparam logic [3:0] OP_LOAD_EXEC = 4'hA;
  localparam logic [3:0] OP_EXEC      = 4'hB;
  localparam logic [3:0] NOP_CODE     = 4'hF;
  typedef enum logic [3:0] {
    FN_ADD, FN_SUB, FN_MUL, FN_DIV, FN_AND, FN_OR, FN_NAND, FN_NOR,
    FN_XOR, FN_XNOR, FN_CMP_EQ, FN_CMP_GT, FN_CMP_LT, FN_SHR, FN_SHL, FN_NOP
  } alu_fn_e;
  typedef enum logic [2:0] {IDLE, RD_A0, RD_A1, RD_B0, RD_B1, ISSUE, WAIT, DONE} state_e;
endpackage

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: byte-stream command front-end that drives one ALU operation and holds its result.
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int         ALU_LAT  = 1,
  parameter logic [3:0] NOP_FUNC = NOP_CODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [3:0]  alu_func,
  input  logic [15:0] alu_out,
  input  logic        arith_flag,
  input  logic        logic_flag,
  input  logic        cmp_flag,
  input  logic        shift_flag,
  output logic [15:0] res_data,
  output logic [3:0]  res_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        cmd_err
);
  localparam int CW = $clog2(ALU_LAT + 1);
  state_e        state;
  logic [3:0]    func;
  logic [CW-1:0] cnt;
  logic          take;
  logic [3:0]    op;
  assign rx_ready = state inside {IDLE, RD_A0, RD_A1, RD_B0, RD_B1};
  assign take     = rx_valid && rx_ready;
  assign op       = rx_data[7:4];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      func      <= 4'h0;
      cnt       <= '0;
      a         <= 16'h0000;
      b         <= 16'h0000;
      alu_func  <= NOP_FUNC;
      res_data  <= 16'h0000;
      res_flags <= 4'h0;
      res_valid <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (state)
        IDLE: if (take) begin
          if (op == OP_LOAD_EXEC) begin
            func  <= rx_data[3:0];
            state <= RD_A0;
          end else if (op == OP_EXEC) begin
            func     <= rx_data[3:0];
            alu_func <= rx_data[3:0];
            state    <= ISSUE;
          end else cmd_err <= 1'b1;
        end
        RD_A0: if (take) begin
          a[7:0] <= rx_data;
          state  <= RD_A1;
        end
        RD_A1: if (take) begin
          a[15:8] <= rx_data;
          state   <= RD_B0;
        end
        RD_B0: if (take) begin
          b[7:0] <= rx_data;
          state  <= RD_B1;
        end
        RD_B1: if (take) begin
          b[15:8]  <= rx_data;
          alu_func <= func;
          state    <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (cnt == CW'(ALU_LAT - 1)) begin
          res_data  <= alu_out;
          res_flags <= {arith_flag, logic_flag, cmp_flag, shift_flag};
          res_valid <= 1'b1;
          alu_func  <= NOP_FUNC;
          state     <= DONE;
        end else cnt <= cnt + CW'(1);
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: scoreboard bench driving two front-ends (ALU latency 1 and 3), each beside a behavioural ALU.
module tb_alu_cmd_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data [2];
  logic        rx_valid [2];
  logic        rx_ready [2];
  logic [15:0] a [2];
  logic [15:0] b [2];
  logic [3:0]  alu_func [2];
  logic [15:0] alu_out [2];
  logic [3:0]  aflags [2];
  logic [15:0] res_data [2];
  logic [3:0]  res_flags [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic        cmd_err [2];
  int errors = 0;
  int checks = 0;
  typedef struct {logic [15:0] data; logic [3:0] flags; logic [3:0] fn;} exp_t;
  exp_t sbq[$];
  always #5 clk = ~clk;
  function automatic logic [19:0] alu_f(logic [3:0] f, logic [15:0] x, logic [15:0] y);
    logic [15:0] r;
    logic [3:0]  fl;
    r  = f == 4'd0 ? x + y : f == 4'd1 ? x - y : f == 4'd2 ? 16'(x * y) : f == 4'd4 ? x & y :
         f == 4'd5 ? x | y : f == 4'd13 ? x >> 1 : f == 4'd14 ? x << 1 : 16'h0000;
    fl = f <= 4'd3 ? 4'b1000 : f <= 4'd9 ? 4'b0100 : f <= 4'd12 ? 4'b0010 : f <= 4'd14 ? 4'b0001 : 4'b0000;
    return {fl, r};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = g == 0 ? 1 : 3;
    logic [19:0] pipe [L];
    always @(posedge clk) begin
      pipe[0] <= alu_f(alu_func[g], a[g], b[g]);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_out[g] = pipe[L-1][15:0];
    assign aflags[g]  = pipe[L-1][19:16];
    alu_cmd_ctrl #(.ALU_LAT(L)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
      .a(a[g]), .b(b[g]), .alu_func(alu_func[g]), .alu_out(alu_out[g]),
      .arith_flag(aflags[g][3]), .logic_flag(aflags[g][2]), .cmp_flag(aflags[g][1]), .shift_flag(aflags[g][0]),
      .res_data(res_data[g]), .res_flags(res_flags[g]), .res_valid(res_valid[g]), .res_ready(res_ready[g]),
      .cmd_err(cmd_err[g])
    );
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_reset(int d);
    check("rst_a", 32'(a[d]), 32'h0);
    check("rst_b", 32'(b[d]), 32'h0);
    check("rst_func", 32'(alu_func[d]), 32'hF);
    check("rst_data", 32'(res_data[d]), 32'h0);
    check("rst_flags", 32'(res_flags[d]), 32'h0);
    check("rst_valid", 32'(res_valid[d]), 32'h0);
    check("rst_err", 32'(cmd_err[d]), 32'h0);
    check("rst_ready", 32'(rx_ready[d]), 32'h1);
  endtask
  task automatic send(int d, logic [7:0] v);
    int n = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_data[d]  = v;
    rx_valid[d] = 1'b1;
    while (!rx_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rx_timeout", 32'(n), 32'h0);
    @(negedge clk);
    rx_valid[d] = 1'b0;
  endtask
  task automatic frame(int d, logic [7:0] cmd, logic [15:0] av, logic [15:0] bv,
                       logic [15:0] ed, logic [3:0] ef, bit load);
    sbq.push_back('{data: ed, flags: ef, fn: cmd[3:0]});
    send(d, cmd);
    if (load) begin
      send(d, av[7:0]);
      send(d, av[15:8]);
      send(d, bv[7:0]);
      send(d, bv[15:8]);
    end
  endtask
  task automatic result(int d, int hold);
    exp_t e;
    int n = 1;
    e = sbq.pop_front();
    while (!res_valid[d] && n < 20) begin
      check("func_busy", 32'(alu_func[d]), 32'(e.fn));
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(d == 0 ? 3 : 5));
    check("res_data", 32'(res_data[d]), 32'(e.data));
    check("res_flags", 32'(res_flags[d]), 32'(e.flags));
    check("func_nop", 32'(alu_func[d]), 32'hF);
    if (hold > 0) begin
      rx_data[d]  = 8'h35;
      rx_valid[d] = 1'b1;
    end
    repeat (hold) begin
      @(negedge clk);
      check("stall_data", 32'(res_data[d]), 32'(e.data));
      check("stall_flags", 32'(res_flags[d]), 32'(e.flags));
      check("stall_valid", 32'(res_valid[d]), 32'h1);
      check("stall_ready", 32'(rx_ready[d]), 32'h0);
      check("stall_err", 32'(cmd_err[d]), 32'h0);
    end
    rx_valid[d]  = 1'b0;
    res_ready[d] = 1'b1;
    @(negedge clk);
    res_ready[d] = 1'b0;
    check("post_valid", 32'(res_valid[d]), 32'h0);
    check("post_ready", 32'(rx_ready[d]), 32'h1);
    check("post_err", 32'(cmd_err[d]), 32'h0);
  endtask
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_data[i]   = 8'h00;
      rx_valid[i]  = 1'b0;
      res_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_reset(d);
      frame(d, 8'hA0, 16'h0055, 16'h00AA, 16'h00FF, 4'b1000, 1'b1);
      result(d, 0);
      frame(d, 8'hB2, 16'h0, 16'h0, 16'h3872, 4'b1000, 1'b0);
      result(d, 0);
      send(d, 8'h35);
      check("err_pulse", 32'(cmd_err[d]), 32'h1);
      check("err_ready", 32'(rx_ready[d]), 32'h1);
      check("err_valid", 32'(res_valid[d]), 32'h0);
      @(negedge clk);
      check("err_clear", 32'(cmd_err[d]), 32'h0);
      check("err_novalid", 32'(res_valid[d]), 32'h0);
      frame(d, 8'hBD, 16'h0, 16'h0, 16'h002A, 4'b0001, 1'b0);
      result(d, 0);
      frame(d, 8'hB0, 16'h0, 16'h0, 16'h00FF, 4'b1000, 1'b0);
      result(d, 10);
      send(d, 8'hA0);
      send(d, 8'h55);
      send(d, 8'h00);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset(d);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_hold_valid", 32'(res_valid[d]), 32'h0);
      frame(d, 8'hA4, 16'h0055, 16'h00AA, 16'h0000, 4'b0100, 1'b1);
      result(d, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command front-end that sits directly upstream of the 16-bit ALU stage. It accepts a byte stream over a valid/ready handshake, assembles a command frame (function code plus optional 16-bit A/B operands), and drives A, B and ALU_FUNC into the ALU for one operation. It then captures ALU_OUT and the four class flags after the ALU's registered latency and presents them as a held result with a valid/ready handshake.

## Interface
- ALU_LAT, 1, cycles from an ALU_FUNC/A/B change to a valid registered ALU_OUT; legal range 1–4.
- NOP_FUNC, 4'hF, function code driven whenever no operation is in flight.
- CLK  in  1  single clock for the block and the ALU.
- RST  in  1  reset; asynchronous, active-low.
- RX_DATA  in  8  command/operand byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  block can accept a byte; a byte transfers on a rising edge with RX_VALID && RX_READY.
- A, B  out  16 each  operands to ALU.
- ALU_FUNC  out  4  function code to ALU.
- ALU_OUT  in  16  ALU result.
- Arith_flag, Logic_flag, CMP_flag, Shift_flag  in  1 each  ALU class flags.
- RES_DATA  out  16  captured result.
- RES_FLAGS  out  4  captured flags {Arith, Logic, CMP, Shift} (bit 3 to bit 0).
- RES_VALID  out  1  result held and valid.
- RES_READY  in  1  consumer accepts the result on a rising edge with RES_VALID && RES_READY.
- CMD_ERR  out  1  one-cycle pulse when an illegal command byte is consumed.

## Operation
- Command byte: bits [7:4] are the opcode, bits [3:0] are the function code.
  - Opcode 4'hA (LOAD_EXEC): four operand bytes follow in the order A_lo, A_hi, B_lo, B_hi (little-endian).
  - Opcode 4'hB (EXEC): no operand bytes; the stored A/B registers are reused.
  - Any other opcode: the byte is consumed, CMD_ERR pulses, and the state stays IDLE.
- FSM states: IDLE, RD_A0, RD_A1, RD_B0, RD_B1, ISSUE, WAIT, DONE.
  - IDLE: a LOAD_EXEC byte moves to RD_A0; an EXEC byte moves to ISSUE.
  - RD_A0 → RD_A1 → RD_B0 → RD_B1 → ISSUE, advancing only on an accepted byte.
  - ISSUE → WAIT → … → DONE. WAIT lasts ALU_LAT cycles, counted by a wait counter of width ceil(log2(ALU_LAT+1)).
  - DONE → IDLE on a RES_VALID && RES_READY transfer.
- The function code is latched into a FUNC register when the command byte is accepted.
  - ALU_FUNC = FUNC during ISSUE and WAIT; ALU_FUNC = NOP_FUNC in every other state.
- Operand bytes are written into the A/B registers as they are accepted. A and B keep their values until the next LOAD_EXEC overwrites them.
  - A partially received frame has already overwritten the bytes it delivered.
- Capture: on the clock edge that ends the last WAIT cycle, RES_DATA ← ALU_OUT and RES_FLAGS ← flags.
- RES_DATA and RES_FLAGS are stable throughout DONE.
- RX_READY = 1 in IDLE and in the RD_* states, and 0 in ISSUE, WAIT and DONE. This is combinational from the state register.
- RES_VALID = 1 only in DONE, registered.
- Result stall: if RES_READY stays low, the block holds DONE indefinitely and accepts no bytes.
- No timeout: a stalled partial frame waits in its RD_* state indefinitely.

## Timing
- Reset values (asynchronous assertion, synchronous-safe release):
  - State = IDLE; A = B = 16'h0000; FUNC = 4'h0; ALU_FUNC = NOP_FUNC.
  - RES_DATA = 16'h0000; RES_FLAGS = 4'h0; RES_VALID = 0; CMD_ERR = 0; RX_READY = 1.
- Reset mid-frame or mid-operation: the frame is discarded, all registers return to their reset values, and no result is produced.
- Latency, with the last frame byte accepted at edge k:
  - ISSUE runs during cycle k → k+1.
  - Capture happens at edge k+1+ALU_LAT.
  - RES_VALID is high starting the cycle after that edge: 2+ALU_LAT cycles after edge k (3 cycles for ALU_LAT = 1).
- Back-to-back: after a result is accepted at edge m, RX_READY is high in the cycle after edge m. No overlap of frames with in-flight operations.
- CMD_ERR is high for exactly one cycle, the cycle after the edge that consumed the illegal byte.

## Structure
- Shared package alu_ctrl_pkg holds:
  - Opcode constants OP_LOAD_EXEC = 4'hA and OP_EXEC = 4'hB.
  - The NOP function code 4'hF and the ALU function-code constants (ADD = 0 … NOP = 15).
  - The FSM state encoding.
- Single module with no sub-module. ALU_RTL is instantiated beside alu_cmd_ctrl at the next level up, not inside it.

## Test plan
- LOAD_EXEC ADD: bytes 0xA0, 0x55, 0x00, 0xAA, 0x00 with ALU_LAT = 1 → RES_DATA = 0x00FF, RES_FLAGS = 4'b1000, RES_VALID exactly 3 cycles after the last byte.
- EXEC MUL reusing the operands: byte 0xB2 → RES_DATA = 0x3872, RES_FLAGS = 4'b1000. ALU_FUNC = 2 only in ISSUE/WAIT, otherwise 0xF.
- Illegal byte 0x35 → CMD_ERR pulses for 1 cycle, no RES_VALID, RX_READY stays 1. A following 0xBD (shift right of A = 0x0055) → 0x002A, flags 4'b0001.
- RES_READY held low for 10 cycles during DONE → RES_DATA/RES_FLAGS stable, RX_READY = 0, and RX_VALID bytes offered during the stall are not consumed.
- RST pulsed low after byte 3 of a LOAD_EXEC → all outputs at reset values. A fresh frame 0xA4, 0x55, 0x00, 0xAA, 0x00 (AND) → 0x0000, flags 4'b0100.
- RX_VALID gaps of 0–3 random idle cycles between bytes, and ALU_LAT = 3 build → same results as above, RES_VALID 5 cycles after the last byte.
